// File: rtl/key_expansion_if.sv
// Purpose: handshake/bus bundle between a key consumer and the key_expansion block.
// Latency: none, wires only.
// Backpressure: key_ready from the consumer stalls key_valid/round_key at the producer.
// Signals: start/key_in request an expansion; round_key/key_round/key_valid/key_ready
//          carry round keys out; busy and done report block status.
interface key_expansion_if;
    logic         start;
    logic [127:0] key_in;
    logic [127:0] round_key;
    logic [3:0]   key_round;
    logic         key_valid;
    logic         key_ready;
    logic         busy;
    logic         done;

    // master: the side requesting keys and consuming them
    modport master (
        output start, key_in, key_ready,
        input  round_key, key_round, key_valid, busy, done
    );

    // slave: the key_expansion block
    modport slave (
        input  start, key_in, key_ready,
        output round_key, key_round, key_valid, busy, done
    );
endinterface

// File: rtl/key_expansion.sv
// Purpose: AES-128 key schedule, emitting round keys 0..LAST_ROUND one per accepted transfer.
// Latency: first key 1 cycle after start; each further key 1 cycle after the previous transfer.
// Backpressure: key_ready=0 holds key_valid high with round_key/key_round frozen.
// Ports: clk, rst (sync, active-high); kx (slave) carries start, key_in, key_ready in and
//        round_key, key_round, key_valid, busy, done out. All outputs come from flops.

// Combinational AES S-box: multiplicative inverse in GF(2^8) followed by the affine map.
module aes_sbox (
    input  logic [7:0] a,
    output logic [7:0] s
);
    function automatic logic [7:0] gf_mul(input logic [7:0] x, input logic [7:0] y);
        logic [7:0] p;
        logic [7:0] t;
        p = 8'h00;
        t = x;
        for (int i = 0; i < 8; i++) begin
            if (y[i]) p = p ^ t;
            t = {t[6:0], 1'b0} ^ (t[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    logic [7:0] x2, x3, x6, x12, x15, x30, x60, x120, x240, inv;

    // inverse = a^254 (0 maps to 0 naturally); 254 = 240 + 12 + 2
    always_comb begin
        x2   = gf_mul(a, a);
        x3   = gf_mul(x2, a);
        x6   = gf_mul(x3, x3);
        x12  = gf_mul(x6, x6);
        x15  = gf_mul(x12, x3);
        x30  = gf_mul(x15, x15);
        x60  = gf_mul(x30, x30);
        x120 = gf_mul(x60, x60);
        x240 = gf_mul(x120, x120);
        inv  = gf_mul(gf_mul(x240, x12), x2);
        s    = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                   ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    end
endmodule

// Round constant for rounds 1..10, placed in the most significant byte.
module aes_rcon (
    input  logic [3:0]  round_num,
    output logic [31:0] rcon
);
    always_comb begin
        rcon = 32'h0;
        case (round_num)
            4'd1:    rcon = 32'h01000000;
            4'd2:    rcon = 32'h02000000;
            4'd3:    rcon = 32'h04000000;
            4'd4:    rcon = 32'h08000000;
            4'd5:    rcon = 32'h10000000;
            4'd6:    rcon = 32'h20000000;
            4'd7:    rcon = 32'h40000000;
            4'd8:    rcon = 32'h80000000;
            4'd9:    rcon = 32'h1b000000;
            4'd10:   rcon = 32'h36000000;
            default: rcon = 32'h0;
        endcase
    end
endmodule

module key_expansion #(
    parameter logic [3:0] LAST_ROUND = 4'ha
) (
    input  logic            clk,
    input  logic            rst,
    key_expansion_if.slave  kx
);
    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

    state_t         state_q, state_nxt;
    logic [127:0]   round_key_q;
    logic [3:0]     key_round_q;
    logic           done_q;
    logic           key_valid_o, busy_o, xfer, last;

    // next-round datapath
    logic [31:0]    w0, w1, w2, w3, rot, sub, rc, t, w4, w5, w6, w7;
    logic [3:0]     round_nxt;

    // state register
    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_nxt;
    end

    // next-state logic; start is only looked at in IDLE, so a start during RUN is ignored
    always_comb begin
        state_nxt = state_q;
        case (state_q)
            IDLE:    if (kx.start)    state_nxt = RUN;
            RUN:     if (xfer && last) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // outputs decoded from the state register only, so no input reaches them combinationally
    always_comb begin
        key_valid_o = (state_q == RUN);
        busy_o      = (state_q != IDLE);
        xfer        = (state_q == RUN) && kx.key_ready;
        // >= keeps key_round from ever stepping past LAST_ROUND
        last        = (key_round_q >= LAST_ROUND);
    end

    assign w0        = round_key_q[127:96];
    assign w1        = round_key_q[95:64];
    assign w2        = round_key_q[63:32];
    assign w3        = round_key_q[31:0];
    assign rot       = {w3[23:0], w3[31:24]};
    assign round_nxt = key_round_q + 4'd1;

    aes_sbox u_sb3 (.a(rot[31:24]), .s(sub[31:24]));
    aes_sbox u_sb2 (.a(rot[23:16]), .s(sub[23:16]));
    aes_sbox u_sb1 (.a(rot[15:8]),  .s(sub[15:8]));
    aes_sbox u_sb0 (.a(rot[7:0]),   .s(sub[7:0]));
    aes_rcon u_rcon (.round_num(round_nxt), .rcon(rc));

    assign t  = sub ^ rc;
    assign w4 = w0 ^ t;
    assign w5 = w1 ^ w4;
    assign w6 = w2 ^ w5;
    assign w7 = w3 ^ w6;

    // key registers: load on start, advance on a non-final transfer, otherwise hold
    always_ff @(posedge clk) begin
        if (rst) begin
            round_key_q <= 128'h0;
            key_round_q <= 4'd0;
            done_q      <= 1'b0;
        end else begin
            done_q <= xfer && last;
            if (state_q == IDLE && kx.start) begin
                round_key_q <= kx.key_in;
                key_round_q <= 4'd0;
            end else if (xfer && !last) begin
                round_key_q <= {w4, w5, w6, w7};
                key_round_q <= round_nxt;
            end
        end
    end

    assign kx.round_key = round_key_q;
    assign kx.key_round = key_round_q;
    assign kx.key_valid = key_valid_o;
    assign kx.busy      = busy_o;
    assign kx.done      = done_q;
endmodule

// File: tb/tb_key_expansion.sv
// Purpose: directed checks of key_expansion against FIPS-197 and all-zero key schedules.
// Latency: n/a (bench).
// Backpressure: key_ready driven high or randomly low to exercise stalls.
module tb_key_expansion;
    logic clk;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    key_expansion_if kif ();
    key_expansion_if kif3 ();

    key_expansion #(.LAST_ROUND(4'ha)) u_dut  (.clk(clk), .rst(rst), .kx(kif.slave));
    key_expansion #(.LAST_ROUND(4'h3)) u_dut3 (.clk(clk), .rst(rst), .kx(kif3.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] ZERO_R1  = 128'h62636363626363636263636362636363;
    localparam logic [127:0] ZERO_R10 = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

    logic [127:0] exp_fips [0:10] = '{
        128'h2b7e151628aed2a6abf7158809cf4f3c,
        128'ha0fafe1788542cb123a339392a6c7605,
        128'hf2c295f27a96b9435935807a7359f67f,
        128'h3d80477d4716fe3e1e237e446d7a883b,
        128'hef44a541a8525b7fb671253bdb0bad00,
        128'hd4d1c6f87c839d87caf2b8bc11f915bc,
        128'h6d88a37a110b3efddbf98641ca0093fd,
        128'h4e54f70e5f5fc9f384a64fb24ea6dc4f,
        128'head27321b58dbad2312bf5607f8d292f,
        128'hac7766f319fadc2128d12941575c006e,
        128'hd014f9a8c9ee2589e13f0cc8b6630ca6
    };

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic start_key(input logic [127:0] key);
        kif.start  = 1'b1;
        kif.key_in = key;
        @(negedge clk);
        kif.start  = 1'b0;
    endtask

    // Consumes one full schedule, called on the negedge where round 0 should be visible.
    // Ends on the negedge where done is expected.
    task automatic run_seq(input string tag, input bit zero_key, input bit rnd,
                           input bit inject, input int want_vcnt);
        int           idx;
        int           vcnt;
        bit           finished;
        bit           known;
        bit           rdy;
        logic [127:0] e;
        idx = 0; vcnt = 0; finished = 1'b0;
        for (int c = 0; c < 300 && !finished; c++) begin
            if (kif.key_valid === 1'b1 && idx <= 10) begin
                vcnt++;
                if (zero_key) begin
                    known = (idx == 0 || idx == 1 || idx == 10);
                    e = (idx == 0) ? 128'h0 : (idx == 1) ? ZERO_R1 : ZERO_R10;
                end else begin
                    known = 1'b1;
                    e = exp_fips[idx];
                end
                chk($sformatf("%s_round_r%0d", tag, idx), {124'h0, kif.key_round}, idx);
                if (known) chk($sformatf("%s_key_r%0d", tag, idx), kif.round_key, e);
                chk($sformatf("%s_busy_r%0d", tag, idx), {127'h0, kif.busy}, 1);
                chk($sformatf("%s_nodone_r%0d", tag, idx), {127'h0, kif.done}, 0);
                rdy = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
                kif.key_ready = rdy;
                if (inject && idx == 4) begin
                    kif.start  = 1'b1;
                    kif.key_in = ~FIPS_KEY;
                end else begin
                    kif.start  = 1'b0;
                end
                if (rdy) idx++;
                @(negedge clk);
            end else begin
                finished = 1'b1;
            end
        end
        kif.start     = 1'b0;
        kif.key_ready = 1'b0;
        chk({tag, "_all_keys"}, idx, 11);
        if (want_vcnt > 0) chk({tag, "_valid_cycles"}, vcnt, want_vcnt);
        chk({tag, "_done"},      {127'h0, kif.done},      1);
        chk({tag, "_valid_off"}, {127'h0, kif.key_valid}, 0);
        chk({tag, "_busy_off"},  {127'h0, kif.busy},      0);
        chk({tag, "_hold_round"}, {124'h0, kif.key_round}, 10);
        if (!zero_key) chk({tag, "_hold_key"}, kif.round_key, exp_fips[10]);
        else           chk({tag, "_hold_key"}, kif.round_key, ZERO_R10);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int c;
        rst = 1'b1;
        kif.start = 1'b0;  kif.key_in = '0;  kif.key_ready = 1'b0;
        kif3.start = 1'b0; kif3.key_in = '0; kif3.key_ready = 1'b0;
        repeat (3) @(negedge clk);

        // reset state
        chk("rst_valid", {127'h0, kif.key_valid}, 0);
        chk("rst_busy",  {127'h0, kif.busy},      0);
        chk("rst_done",  {127'h0, kif.done},      0);
        chk("rst_round", {124'h0, kif.key_round}, 0);
        chk("rst_key",   kif.round_key,           0);
        rst = 1'b0;
        @(negedge clk);

        // FIPS-197 key, consumer always ready: 11 back-to-back keys
        start_key(FIPS_KEY);
        run_seq("fips", 1'b0, 1'b0, 1'b0, 11);

        // start during the done cycle is accepted; zero key follows
        start_key(128'h0);
        chk("chain_start_busy", {127'h0, kif.busy}, 1);
        run_seq("zero", 1'b1, 1'b0, 1'b0, 11);
        @(negedge clk);
        chk("zero_done_once", {127'h0, kif.done}, 0);

        // random backpressure
        start_key(FIPS_KEY);
        run_seq("bp", 1'b0, 1'b1, 1'b0, 0);
        @(negedge clk);

        // start with another key during RUN is ignored
        start_key(FIPS_KEY);
        run_seq("inj", 1'b0, 1'b0, 1'b1, 11);
        @(negedge clk);

        // reset at key_round 5, with a transfer pending on the same edge
        start_key(FIPS_KEY);
        kif.key_ready = 1'b1;
        c = 0;
        while (kif.key_round !== 4'd5 && c < 20) begin
            @(negedge clk);
            c++;
        end
        chk("mid_reached_r5", {124'h0, kif.key_round}, 5);
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_valid", {127'h0, kif.key_valid}, 0);
        chk("mid_rst_busy",  {127'h0, kif.busy},      0);
        chk("mid_rst_round", {124'h0, kif.key_round}, 0);
        chk("mid_rst_key",   kif.round_key,           0);
        chk("mid_rst_done",  {127'h0, kif.done},      0);
        rst = 1'b0;
        kif.key_ready = 1'b0;
        @(negedge clk);
        chk("mid_rst_done2", {127'h0, kif.done}, 0);
        start_key(FIPS_KEY);
        run_seq("after_rst", 1'b0, 1'b0, 1'b0, 11);
        @(negedge clk);

        // LAST_ROUND = 3: rounds 0..3 then done
        kif3.start  = 1'b1;
        kif3.key_in = FIPS_KEY;
        @(negedge clk);
        kif3.start     = 1'b0;
        kif3.key_ready = 1'b1;
        for (int r = 0; r < 4; r++) begin
            chk($sformatf("lr3_valid_r%0d", r), {127'h0, kif3.key_valid}, 1);
            chk($sformatf("lr3_round_r%0d", r), {124'h0, kif3.key_round}, r);
            chk($sformatf("lr3_key_r%0d", r),   kif3.round_key,           exp_fips[r]);
            @(negedge clk);
        end
        kif3.key_ready = 1'b0;
        chk("lr3_valid_off", {127'h0, kif3.key_valid}, 0);
        chk("lr3_done",      {127'h0, kif3.done},      1);
        chk("lr3_hold_round", {124'h0, kif3.key_round}, 3);
        chk("lr3_hold_key",  kif3.round_key,           exp_fips[3]);
        @(negedge clk);
        chk("lr3_done_once", {127'h0, kif3.done}, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/key_expansion.md
KEY_EXPANSION -- requirements
Module: key_expansion

Interface
REQ-001 The block SHALL have parameter LAST_ROUND, default 4'ha, the final round index generated; legal range 4'h1..4'ha.
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1, reset, synchronous and active-high.
REQ-004 The block SHALL have port start, input, 1, request to expand key_in; sampled only in IDLE.
REQ-005 The block SHALL have port key_in, input, 128, AES-128 cipher key; w0 = key_in[127:96], w3 = key_in[31:0].
REQ-006 The block SHALL have port round_key, output, 128, current round key, with the same word order as key_in.
REQ-007 The block SHALL have port key_round, output, 4, index of round_key, 0..LAST_ROUND.
REQ-008 The block SHALL have port key_valid, output, 1, round_key/key_round valid.
REQ-009 The block SHALL have port key_ready, input, 1, consumer accepts round_key this cycle.
REQ-010 The block SHALL have port busy, output, 1, high whenever state != IDLE.
REQ-011 The block SHALL have port done, output, 1, one-cycle pulse after the last key is accepted.

Function
REQ-012 The block SHALL use a 2-state FSM: IDLE and RUN.
REQ-013 IDLE with start=1: the block SHALL register key_in into round_key, set key_round=0, key_valid=1 and go to RUN; first key visible 1 cycle after start.
REQ-014 Start while in RUN SHALL be ignored, with no effect on key, round, or state.
REQ-015 In RUN, key_valid SHALL stay 1 and round_key/key_round SHALL hold stable while key_ready=0 (no drop, no advance).
REQ-016 A transfer (key_valid=1 and key_ready=1) with key_round < LAST_ROUND SHALL register the next round key and set key_round+1 in the same edge, so key_valid stays high and each transfer costs one cycle.
REQ-017 The next key SHALL be t = SubWord(RotWord(w3)) ^ RCj(key_round+1); w4=w0^t; w5=w1^w4; w6=w2^w5; w7=w3^w6.
REQ-018 RotWord SHALL be {w3[23:0], w3[31:24]}.
REQ-019 SubWord SHALL apply the AES S-box to each byte independently, using four instances of the team's combinational S-box module.
REQ-020 RCj SHALL come from an instance of the team's round-constant module driven with round_num = key_round+1 (4 bits), with the constant in the MSB byte (e.g. round 1 = 32'h01000000, round 9 = 32'h1b000000).
REQ-021 A transfer with key_round == LAST_ROUND SHALL, next cycle, set key_valid=0, go to IDLE, and pulse done=1 for exactly one cycle.
REQ-022 round_key and key_round SHALL retain their last values in IDLE.
REQ-023 The block SHALL use no combinational path from key_ready or start to any output; all outputs SHALL be registered.
REQ-024 A start sampled in the same cycle as done=1 (state IDLE) SHALL be accepted normally.
REQ-025 The 4-bit key_round SHALL never wrap; it SHALL not increment beyond LAST_ROUND.

Reset
REQ-026 rst=1 SHALL force state IDLE, key_valid=0, busy=0, done=0, key_round=0 and round_key=128'h0 on the next edge.
REQ-027 rst SHALL take priority over start and over any transfer, including mid-RUN.
REQ-028 After rst is released, the block SHALL accept a new start with no residual state.

Verification
REQ-029 The bench SHALL cover the FIPS-197 key 2b7e151628aed2a6abf7158809cf4f3c with key_ready=1: key_valid high for 11 consecutive cycles; round 1 = a0fafe1788542cb123a339392a6c7605; round 10 = d014f9a8c9ee2589e13f0cc8b6630ca6; done pulses once, 1 cycle after the round-10 transfer.
REQ-030 The bench SHALL cover the all-zero key: round 1 = 62636363626363636263636362636363; round 10 = b4ef5bcb3e92e21123e951cf6f8f188e.
REQ-031 The bench SHALL cover backpressure, with key_ready randomly low 50%: the key sequence is identical to REQ-029, and round_key and key_round are stable during every stall cycle.
REQ-032 The bench SHALL cover start pulsed with a different key during RUN: it is ignored, and the sequence is still the original key's.
REQ-033 The bench SHALL cover rst asserted at key_round=5: next cycle key_valid=0, busy=0, key_round=0, round_key=0, and no done; a subsequent start produces the full correct sequence.
REQ-034 The bench SHALL cover LAST_ROUND=4'h3: exactly 4 keys (rounds 0..3) are produced, then done is pulsed.
